req_grant_arbiter: RTL and testbench
====================================

REQ_GRANT_ARBITER -- requirements
Module: req_grant_arbiter

Interface
REQ-001 Parameter N, default 4, number of requesters, range 2..16.
REQ-002 Parameter MAX_HOLD, default 8, maximum consecutive grant cycles per owner, range 1..255.
REQ-003 clk  input  1  single clock, all state updates on posedge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 req  input  N  per-requester request level, bit i = requester i.
REQ-006 grant  output  N  one-hot grant vector, all-zero when nothing is granted.
REQ-007 grant_valid  output  1  OR of grant.
REQ-008 grant_id  output  $clog2(N)  index of the granted requester, 0 when grant_valid=0.
REQ-009 timeout  output  1  one-cycle pulse, registered, on a forced revoke.

Function
REQ-010 The grant path SHALL be combinational from req and registered state, so that a request rising at a posedge is granted in that same cycle when it is eligible (zero-cycle grant latency).
REQ-011 State machine SHALL have the states IDLE (no owner) and OWNED (owner register valid).
REQ-012 IDLE: if any eligible req bit is set, grant the first eligible index found scanning upward from ptr with wrap; the next state is OWNED with owner=that index and hold_cnt=1.
REQ-013 OWNED, req[owner]=1, hold_cnt<MAX_HOLD: grant stays on owner; hold_cnt increments, saturating at MAX_HOLD.
REQ-014 OWNED, req[owner]=0: grant[owner] SHALL deassert in that same cycle; ptr becomes owner+1 mod N; any other eligible requester SHALL be granted in that same cycle using the new ptr scan (back-to-back handover, no idle bubble).
REQ-015 OWNED, req[owner]=1, hold_cnt==MAX_HOLD: grant is revoked in that cycle; timeout pulses in the next cycle; the owner's bit is set in the mask register; ptr becomes owner+1 mod N; the handover follows REQ-014.
REQ-016 Eligible = req & ~mask; a mask bit SHALL clear on the first cycle its req bit is 0.
REQ-017 At most one grant bit SHALL be set in any cycle; a grant bit SHALL never be set while its req bit is 0.
REQ-018 Simultaneous requests in IDLE: the lowest index at or after ptr wins; other requesters wait with no loss of request.
REQ-019 Pointer wrap: ptr=N-1 followed by release SHALL give ptr=0.
REQ-020 If a requester is granted and its req drops in the same cycle as a different req rises, the rising req SHALL receive grant in that cycle when it is first in scan order.
REQ-021 hold_cnt width SHALL be 8 bits; the count includes the grant cycle itself.

Reset
REQ-022 While rst=1: state=IDLE, ptr=0, owner=0, hold_cnt=0, mask=0, timeout=0, grant=0, grant_valid=0, grant_id=0, regardless of req.
REQ-023 rst asserted mid-ownership SHALL drop grant immediately (asynchronously); after rst deasserts, arbitration restarts from ptr=0 on the first posedge.

Structure
REQ-024 The package arb_pkg SHALL hold the state enum (IDLE, OWNED), the default N and MAX_HOLD constants, and a function that returns the index of the first set bit in a rotated vector.
REQ-025 One sub-module, rr_pick, SHALL implement the combinational rotate-and-find-first (inputs: vector, ptr; outputs: found, index); req_grant_arbiter instantiates it once.
REQ-026 Concurrent assertions SHALL be included in the module under a synthesis-off guard:
- $rose(req[i]) with no owner and i first in scan order |-> grant[i] in the same cycle;
- $onehot0(grant);
- grant[i] |-> req[i].

Verification
REQ-027 Reset, then req=4'b0001 at t=5 -> grant=4'b0001, grant_id=0, grant_valid=1 in the same cycle; $rose(req)|->grant passes.
REQ-028 ptr=0, req=4'b1010 simultaneous -> grant=4'b0010; requester 1 drops -> grant=4'b1000 in that same cycle; ptr then becomes 2 after the release.
REQ-029 req[2] held for 12 cycles with MAX_HOLD=8 -> grant[2] high for exactly 8 cycles; timeout=1 in cycle 9; grant[2] stays 0 until req[2] drops and re-rises.
REQ-030 Owner 3 releases while req=4'b0001 -> ptr wraps to 0; grant=4'b0001 in the release cycle.
REQ-031 rst pulsed while grant=4'b0100 -> grant=0 immediately; after reset, req=4'b0110 -> grant=4'b0010.
REQ-032 Random req for 2000 cycles -> no onehot0 or grant-without-req violation; every continuously requesting port is granted within N*MAX_HOLD cycles.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the request/grant arbiter.
package arb_pkg;

    localparam int unsigned DEF_N        = 4;
    localparam int unsigned DEF_MAX_HOLD = 8;
    localparam int unsigned MAX_N        = 16;
    localparam int unsigned MAX_IDX_W    = 4;
    localparam int unsigned HOLD_W       = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_e;

    // Index of the first set bit of vec, scanning upward from ptr and wrapping at n.
    function automatic logic [MAX_IDX_W-1:0] first_set_rot(
        input logic [MAX_N-1:0]     vec,
        input logic [MAX_IDX_W-1:0] ptr,
        input int unsigned          n
    );
        logic [MAX_IDX_W-1:0] res;
        logic                 hit;
        int unsigned          j;
        res = '0;
        hit = 1'b0;
        for (int unsigned i = 0; i < MAX_N; i++) begin
            j = 32'(ptr) + i;
            if (j >= n) begin
                j = j - n;
            end
            if (!hit && (i < n) && vec[MAX_IDX_W'(j)]) begin
                res = MAX_IDX_W'(j);
                hit = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-and-find-first: first set bit of vec_i at or after ptr_i.
module rr_pick
    import arb_pkg::*;
#(
    parameter  int unsigned N = DEF_N,
    localparam int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] vec_i,
    input  logic [W-1:0] ptr_i,
    output logic         found_o,
    output logic [W-1:0] index_o
);

    assign found_o = |vec_i;
    assign index_o = W'(first_set_rot(MAX_N'(vec_i), MAX_IDX_W'(ptr_i), N));

endmodule

// File: rtl/req_grant_arbiter.sv
// Round-robin request/grant arbiter with zero-cycle grant, per-owner hold limit and
// a mask that keeps a timed-out owner out until it drops its request.
module req_grant_arbiter
    import arb_pkg::*;
#(
    parameter  int unsigned N        = DEF_N,
    parameter  int unsigned MAX_HOLD = DEF_MAX_HOLD,
    localparam int unsigned W        = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic         grant_valid,
    output logic [W-1:0] grant_id,
    output logic         timeout
);

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [W-1:0]      LAST_IDX = W'(N - 1);

    arb_state_e          state_q, state_d;
    logic [W-1:0]        owner_q, owner_d;
    logic [W-1:0]        ptr_q, ptr_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [N-1:0]        mask_q, mask_d;
    logic                timeout_q, timeout_d;

    logic [N-1:0]        eligible;
    logic [N-1:0]        owner_oh;
    logic [W-1:0]        owner_inc;
    logic                owned;
    logic                keep;
    logic                expire;
    logic [N-1:0]        scan_vec;
    logic [W-1:0]        scan_ptr;
    logic                pick_found;
    logic [W-1:0]        pick_idx;
    logic [N-1:0]        grant_c;
    logic [W-1:0]        id_c;

    assign eligible  = req & ~mask_q;
    assign owner_oh  = N'(1) << owner_q;
    assign owner_inc = (owner_q == LAST_IDX) ? '0 : owner_q + W'(1);
    assign owned     = (state_q == OWNED);
    assign keep      = owned && req[owner_q] && (hold_q < HOLD_MAX);
    assign expire    = owned && req[owner_q] && (hold_q >= HOLD_MAX);

    // A leaving owner hands over using the post-release pointer, excluding itself.
    assign scan_ptr  = owned ? owner_inc : ptr_q;
    assign scan_vec  = owned ? (eligible & ~owner_oh) : eligible;

    rr_pick #(.N(N)) u_pick (
        .vec_i   (scan_vec),
        .ptr_i   (scan_ptr),
        .found_o (pick_found),
        .index_o (pick_idx)
    );

    // Next-state and combinational grant.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        mask_d    = mask_q & req;
        timeout_d = 1'b0;
        grant_c   = '0;
        id_c      = '0;

        if (keep) begin
            grant_c = owner_oh;
            id_c    = owner_q;
            hold_d  = hold_q + HOLD_W'(1);
        end else begin
            if (owned) begin
                ptr_d = owner_inc;
            end
            if (expire) begin
                mask_d    = mask_d | owner_oh;
                timeout_d = 1'b1;
            end
            if (pick_found) begin
                grant_c = N'(1) << pick_idx;
                id_c    = pick_idx;
                state_d = OWNED;
                owner_d = pick_idx;
                hold_d  = HOLD_W'(1);
            end else begin
                state_d = IDLE;
                hold_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            mask_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            mask_q    <= mask_d;
            timeout_q <= timeout_d;
        end
    end

    // Reset kills the grant path immediately, not at the next edge.
    assign grant       = rst ? '0 : grant_c;
    assign grant_valid = |grant;
    assign grant_id    = rst ? '0 : id_c;
    assign timeout     = timeout_q;

`ifndef SYNTHESIS
    for (genvar gi = 0; gi < N; gi++) begin : g_sva
        a_rose_grant: assert property (@(posedge clk) disable iff (rst)
            ($rose(req[gi]) && !owned && pick_found && (pick_idx == W'(gi))) |-> grant[gi]);
        a_grant_req: assert property (@(posedge clk) disable iff (rst)
            grant[gi] |-> req[gi]);
    end
    a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
`endif

endmodule

// File: tb/tb_req_grant_arbiter.sv
// Directed-vector bench for req_grant_arbiter (N=4, MAX_HOLD=8).
module tb_req_grant_arbiter;

    localparam int unsigned N        = 4;
    localparam int unsigned MAX_HOLD = 8;
    localparam int unsigned NROWS    = 17;
    localparam int          BOUND    = N * MAX_HOLD;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic         grant_valid;
    logic [1:0]   grant_id;
    logic         timeout;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] grant;
        logic [1:0] id;
        logic       valid;
    } vec_t;

    vec_t tbl [NROWS];

    req_grant_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic [3:0] r);
        @(posedge clk);
        #1 req = r;
        @(negedge clk);
    endtask

    task automatic chk_all(input string name, input logic [3:0] g, input logic [1:0] id,
                           input logic v, input logic t);
        chk({name, ".grant"},   32'(grant),       32'(g));
        chk({name, ".id"},      32'(grant_id),    32'(id));
        chk({name, ".valid"},   32'(grant_valid), 32'(v));
        chk({name, ".timeout"}, 32'(timeout),     32'(t));
    endtask

    initial begin
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] prev_g1;
        logic [3:0] prev_g2;
        logic [3:0] exempt;
        int         wait_c [N];
        int         worst;

        // req, grant, id, valid  (one row per cycle, starting in IDLE with ptr=0)
        tbl[0]  = '{4'b0000, 4'b0000, 2'd0, 1'b0};
        tbl[1]  = '{4'b0001, 4'b0001, 2'd0, 1'b1};
        tbl[2]  = '{4'b0001, 4'b0001, 2'd0, 1'b1};
        tbl[3]  = '{4'b0000, 4'b0000, 2'd0, 1'b0}; // release, ptr -> 1
        tbl[4]  = '{4'b1010, 4'b0010, 2'd1, 1'b1};
        tbl[5]  = '{4'b1010, 4'b0010, 2'd1, 1'b1};
        tbl[6]  = '{4'b1000, 4'b1000, 2'd3, 1'b1}; // back-to-back handover, ptr -> 2
        tbl[7]  = '{4'b1000, 4'b1000, 2'd3, 1'b1};
        tbl[8]  = '{4'b0001, 4'b0001, 2'd0, 1'b1}; // owner 3 releases, ptr wraps to 0
        tbl[9]  = '{4'b0111, 4'b0001, 2'd0, 1'b1};
        tbl[10] = '{4'b0110, 4'b0010, 2'd1, 1'b1};
        tbl[11] = '{4'b0100, 4'b0100, 2'd2, 1'b1};
        tbl[12] = '{4'b0101, 4'b0100, 2'd2, 1'b1};
        tbl[13] = '{4'b0011, 4'b0001, 2'd0, 1'b1}; // scan from 3 wraps to 0
        tbl[14] = '{4'b1000, 4'b1000, 2'd3, 1'b1}; // drop + rise same cycle
        tbl[15] = '{4'b0000, 4'b0000, 2'd0, 1'b0};
        tbl[16] = '{4'b0000, 4'b0000, 2'd0, 1'b0};

        rst = 1'b1;
        req = 4'b1111;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk_all("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
        req = 4'b0000;

        for (int i = 0; i < int'(NROWS); i++) begin
            step(tbl[i].req);
            chk_all($sformatf("row%0d", i), tbl[i].grant, tbl[i].id, tbl[i].valid, 1'b0);
        end

        // Hold-limit revoke: 8 grant cycles, idle cycle, timeout pulse, then masked.
        for (int c = 0; c < 12; c++) begin
            step(4'b0100);
            chk_all($sformatf("hold%0d", c), (c < 8) ? 4'b0100 : 4'b0000,
                    (c < 8) ? 2'd2 : 2'd0, c < 8, c == 9);
        end
        step(4'b0000);
        chk_all("hold_drop", 4'b0000, 2'd0, 1'b0, 1'b0);
        step(4'b0100);
        chk_all("hold_rerise", 4'b0100, 2'd2, 1'b1, 1'b0);

        // Asynchronous reset mid-ownership.
        #2 rst = 1'b1;
        #1;
        chk_all("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0110;
        #1;
        chk_all("post_rst_comb", 4'b0010, 2'd1, 1'b1, 1'b0);
        step(4'b0110);
        chk_all("post_rst", 4'b0010, 2'd1, 1'b1, 1'b0);

        // Random traffic: exclusivity, no grant without request, bounded wait.
        r       = 4'b0110;
        prev_g1 = 4'b0010;
        prev_g2 = 4'b0010;
        exempt  = 4'b0000;
        for (int i = 0; i < int'(N); i++) wait_c[i] = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int b = 0; b < int'(N); b++) begin
                if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
            end
            step(r);
            g = grant;
            chk("rand_onehot", 32'((g & (g - 4'd1)) == 4'd0), 32'd1);
            chk("rand_grant_req", 32'(g & ~r), 32'd0);
            if (timeout) exempt = exempt | prev_g2;
            exempt = exempt & r;
            worst = 0;
            for (int i = 0; i < int'(N); i++) begin
                if (!r[i] || g[i] || exempt[i]) wait_c[i] = 0;
                else wait_c[i] = wait_c[i] + 1;
                if (wait_c[i] > worst) worst = wait_c[i];
            end
            chk("rand_starve", 32'(worst > BOUND), 32'd0);
            prev_g2 = prev_g1;
            prev_g1 = g;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
